// File: rtl/mem_write_checker.sv
// Watches a processor's store bus and reports whether the program under test
// signalled success, stored outside its scratch window, or ran out of cycles.
module mem_write_checker #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int PASS_ADDR = 100,
    parameter int PASS_DATA = 25,
    parameter int ALLOW_LO  = 96,
    parameter int ALLOW_HI  = 96,
    parameter int TIMEOUT   = 1000,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] DataAdr,
    input  logic [DATA_W-1:0] WriteData,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [CNT_W-1:0]  write_count,
    output logic [CNT_W-1:0]  cycle_count
);

    typedef enum logic [1:0] {
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    localparam logic [ADDR_W-1:0] PASS_A  = ADDR_W'(PASS_ADDR);
    localparam logic [DATA_W-1:0] PASS_D  = DATA_W'(PASS_DATA);
    localparam logic [ADDR_W-1:0] ALLOW_L = ADDR_W'(ALLOW_LO);
    localparam logic [ADDR_W-1:0] ALLOW_H = ADDR_W'(ALLOW_HI);
    // Compared at 64 bits so a budget wider than the counter can never match.
    localparam longint unsigned TO_LAST = (TIMEOUT > 0) ? longint'(TIMEOUT) - 64'd1 : 64'd0;

    state_t stateReg;
    logic   passWrite;
    logic   scratchWrite;
    logic   timeoutHit;

    always_comb begin
        passWrite    = 1'b0;
        scratchWrite = 1'b0;
        if (MemWrite) begin
            passWrite    = (DataAdr == PASS_A) && (WriteData == PASS_D);
            scratchWrite = !passWrite && (DataAdr >= ALLOW_L) && (DataAdr <= ALLOW_H);
        end
        timeoutHit = (TIMEOUT != 0) && (64'(cycle_count) == TO_LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stateReg    <= S_RUN;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            fail_addr   <= '0;
            fail_data   <= '0;
            write_count <= '0;
            cycle_count <= '0;
        end else if (stateReg == S_RUN) begin
            if (scratchWrite && write_count != '1) begin
                write_count <= write_count + 1'b1;
            end
            // A terminating write outranks an expiring budget on the same edge.
            if (passWrite) begin
                stateReg <= S_PASS;
                pass     <= 1'b1;
                done     <= 1'b1;
            end else if (MemWrite && !scratchWrite) begin
                stateReg  <= S_FAIL;
                fail      <= 1'b1;
                done      <= 1'b1;
                fail_addr <= DataAdr;
                fail_data <= WriteData;
            end else if (timeoutHit) begin
                stateReg <= S_TIMEOUT;
                timeout  <= 1'b1;
                done     <= 1'b1;
            end else if (cycle_count != '1) begin
                cycle_count <= cycle_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: four instances with different
// parameters share one store bus; each task checks the relevant instance.
module tb_mem_write_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    logic        dDone, dPass, dFail, dTo;
    logic [31:0] dFailAddr, dFailData;
    logic [15:0] dWc, dCc;
    logic        tDone, tPass, tFail, tTo;
    logic [31:0] tFailAddr, tFailData;
    logic [15:0] tWc, tCc;
    logic        wDone, wPass, wFail, wTo;
    logic [31:0] wFailAddr, wFailData;
    logic [15:0] wWc, wCc;
    logic        sDone, sPass, sFail, sTo;
    logic [31:0] sFailAddr, sFailData;
    logic [3:0]  sWc, sCc;

    mem_write_checker uDef (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .done(dDone), .pass(dPass), .fail(dFail), .timeout(dTo),
        .fail_addr(dFailAddr), .fail_data(dFailData), .write_count(dWc), .cycle_count(dCc)
    );

    mem_write_checker #(.TIMEOUT(10)) uTo (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .done(tDone), .pass(tPass), .fail(tFail), .timeout(tTo),
        .fail_addr(tFailAddr), .fail_data(tFailData), .write_count(tWc), .cycle_count(tCc)
    );

    mem_write_checker #(.ALLOW_LO(96), .ALLOW_HI(100)) uWin (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .done(wDone), .pass(wPass), .fail(wFail), .timeout(wTo),
        .fail_addr(wFailAddr), .fail_data(wFailData), .write_count(wWc), .cycle_count(wCc)
    );

    mem_write_checker #(.CNT_W(4), .TIMEOUT(0)) uSat (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .done(sDone), .pass(sPass), .fail(sFail), .timeout(sTo),
        .fail_addr(sFailAddr), .fail_data(sFailData), .write_count(sWc), .cycle_count(sCc)
    );

    // Called at a negedge; leaves reset released at a negedge.
    task automatic doReset();
        MemWrite = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Called at a negedge; presents one store for exactly one rising edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1;
        DataAdr = a;
        WriteData = d;
        @(negedge clk);
        MemWrite = 1'b0;
        $display("write addr=%0d data=%0d", a, d);
    endtask

    task automatic test_reset();
        @(negedge clk);
        doReset();
        checks++; if (dDone !== 1'b0 || dPass !== 1'b0 || dFail !== 1'b0 || dTo !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got done=%b pass=%b fail=%b to=%b want 0000", dDone, dPass, dFail, dTo);
        end
        checks++; if (dWc !== 16'd0 || dCc !== 16'd0 || dFailAddr !== 32'd0 || dFailData !== 32'd0) begin
            errors++; $display("FAIL reset_regs: got wc=%0d cc=%0d fa=%0d fd=%0d want 0", dWc, dCc, dFailAddr, dFailData);
        end
    endtask

    task automatic test_pass();
        doReset();
        wr(32'd96, 32'd7);
        wr(32'd96, 32'd9);
        checks++; if (dPass !== 1'b0 || dWc !== 16'd2) begin
            errors++; $display("FAIL pass_pre: got pass=%b wc=%0d want pass=0 wc=2", dPass, dWc);
        end
        wr(32'd100, 32'd25);
        checks++; if (dPass !== 1'b1 || dDone !== 1'b1 || dFail !== 1'b0) begin
            errors++; $display("FAIL pass_flags: got pass=%b done=%b fail=%b want 1 1 0", dPass, dDone, dFail);
        end
        checks++; if (dWc !== 16'd2 || dCc !== 16'd2) begin
            errors++; $display("FAIL pass_counts: got wc=%0d cc=%0d want wc=2 cc=2", dWc, dCc);
        end
    endtask

    task automatic test_fail();
        doReset();
        wr(32'd104, 32'd5);
        checks++; if (dFail !== 1'b1 || dDone !== 1'b1 || dFailAddr !== 32'd104 || dFailData !== 32'd5) begin
            errors++; $display("FAIL fail_capture: got fail=%b done=%b fa=%0d fd=%0d want 1 1 104 5", dFail, dDone, dFailAddr, dFailData);
        end
        wr(32'd100, 32'd25);
        wr(32'd108, 32'd77);
        checks++; if (dPass !== 1'b0 || dFail !== 1'b1 || dFailAddr !== 32'd104 || dFailData !== 32'd5) begin
            errors++; $display("FAIL fail_sticky: got pass=%b fail=%b fa=%0d fd=%0d want 0 1 104 5", dPass, dFail, dFailAddr, dFailData);
        end
    endtask

    task automatic test_timeout();
        doReset();
        repeat (9) @(negedge clk);
        checks++; if (tTo !== 1'b0 || tCc !== 16'd9) begin
            errors++; $display("FAIL to_before: got to=%b cc=%0d want 0 9", tTo, tCc);
        end
        @(negedge clk);
        checks++; if (tTo !== 1'b1 || tDone !== 1'b1 || tPass !== 1'b0 || tCc !== 16'd9) begin
            errors++; $display("FAIL to_fire: got to=%b done=%b pass=%b cc=%0d want 1 1 0 9", tTo, tDone, tPass, tCc);
        end
        wr(32'd100, 32'd25);
        repeat (3) @(negedge clk);
        checks++; if (tTo !== 1'b1 || tPass !== 1'b0 || tCc !== 16'd9) begin
            errors++; $display("FAIL to_frozen: got to=%b pass=%b cc=%0d want 1 0 9", tTo, tPass, tCc);
        end
        doReset();
        checks++; if (tTo !== 1'b0 || tDone !== 1'b0 || tCc !== 16'd0) begin
            errors++; $display("FAIL to_restart: got to=%b done=%b cc=%0d want 0 0 0", tTo, tDone, tCc);
        end
    endtask

    task automatic test_coincide();
        doReset();
        repeat (9) @(negedge clk);
        wr(32'd100, 32'd25);
        checks++; if (tPass !== 1'b1 || tTo !== 1'b0 || tFail !== 1'b0) begin
            errors++; $display("FAIL coincide_pass: got pass=%b to=%b fail=%b want 1 0 0", tPass, tTo, tFail);
        end
        doReset();
        repeat (9) @(negedge clk);
        wr(32'd200, 32'd3);
        checks++; if (tFail !== 1'b1 || tTo !== 1'b0 || tFailAddr !== 32'd200) begin
            errors++; $display("FAIL coincide_fail: got fail=%b to=%b fa=%0d want 1 0 200", tFail, tTo, tFailAddr);
        end
    endtask

    task automatic test_window();
        doReset();
        wr(32'd100, 32'd4);
        checks++; if (wPass !== 1'b0 || wFail !== 1'b0 || wWc !== 16'd1) begin
            errors++; $display("FAIL win_tolerate: got pass=%b fail=%b wc=%0d want 0 0 1", wPass, wFail, wWc);
        end
        checks++; if (dFail !== 1'b1 || dFailAddr !== 32'd100 || dFailData !== 32'd4) begin
            errors++; $display("FAIL win_outside: got fail=%b fa=%0d fd=%0d want 1 100 4", dFail, dFailAddr, dFailData);
        end
        wr(32'd100, 32'd25);
        checks++; if (wPass !== 1'b1 || wWc !== 16'd1) begin
            errors++; $display("FAIL win_pass: got pass=%b wc=%0d want 1 1", wPass, wWc);
        end
        doReset();
        wr(32'd95, 32'd1);
        checks++; if (wFail !== 1'b1 || wFailAddr !== 32'd95) begin
            errors++; $display("FAIL win_below: got fail=%b fa=%0d want 1 95", wFail, wFailAddr);
        end
    endtask

    task automatic test_idle_bus();
        doReset();
        DataAdr = 'x;
        WriteData = 'x;
        repeat (4) @(negedge clk);
        checks++; if (dDone !== 1'b0 || dWc !== 16'd0 || dCc !== 16'd4) begin
            errors++; $display("FAIL idle_bus: got done=%b wc=%0d cc=%0d want 0 0 4", dDone, dWc, dCc);
        end
    endtask

    task automatic test_reset_priority();
        doReset();
        wr(32'd96, 32'd1);
        reset = 1'b0;
        wr(32'd100, 32'd25);
        checks++; if (dPass !== 1'b0 || dDone !== 1'b0 || dWc !== 16'd0 || dCc !== 16'd0) begin
            errors++; $display("FAIL reset_prio: got pass=%b done=%b wc=%0d cc=%0d want 0 0 0 0", dPass, dDone, dWc, dCc);
        end
        reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        doReset();
        for (int i = 0; i < 20; i++) begin
            wr(32'd96, 32'(i));
        end
        checks++; if (sWc !== 4'd15 || sCc !== 4'd15 || sDone !== 1'b0) begin
            errors++; $display("FAIL sat_counts: got wc=%0d cc=%0d done=%b want 15 15 0", sWc, sCc, sDone);
        end
        checks++; if (dWc !== 16'd20 || dCc !== 16'd20) begin
            errors++; $display("FAIL b2b_counts: got wc=%0d cc=%0d want 20 20", dWc, dCc);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_coincide();
        test_window();
        test_idle_bus();
        test_reset_priority();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning width of the write-address bus.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning width of the write-data bus.
REQ-003 The block SHALL have parameter PASS_ADDR, default 100, meaning the address whose write ends the test.
REQ-004 The block SHALL have parameter PASS_DATA, default 25, meaning the data value that signals success at PASS_ADDR.
REQ-005 The block SHALL have parameters ALLOW_LO and ALLOW_HI, both default 96, meaning the inclusive address window for tolerated scratch writes.
REQ-006 The block SHALL have parameter TIMEOUT, default 1000, meaning the cycle budget; a value of 0 disables the timeout.
REQ-007 The block SHALL have parameter CNT_W, default 16, meaning the width of the write and cycle counters.
REQ-008 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-009 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-010 The block SHALL have port MemWrite, input, 1 bit: store strobe from the DUT.
REQ-011 The block SHALL have port DataAdr, input, ADDR_W bits: store address.
REQ-012 The block SHALL have port WriteData, input, DATA_W bits: store data.
REQ-013 The block SHALL have port done, output, 1 bit: asserted in any terminal state.
REQ-014 The block SHALL have ports pass, fail and timeout, each output, 1 bit: one-hot terminal status.
REQ-015 The block SHALL have ports fail_addr and fail_data, outputs of ADDR_W and DATA_W bits: the captured offending write.
REQ-016 The block SHALL have port write_count, output, CNT_W bits: number of accepted scratch writes.
REQ-017 The block SHALL have port cycle_count, output, CNT_W bits: number of RUN cycles elapsed.

Function
REQ-018 The FSM SHALL have states RUN, PASS, FAIL and TIMEOUT; PASS, FAIL and TIMEOUT SHALL be sticky until reset.
REQ-019 In RUN, a sampled MemWrite=1 with DataAdr==PASS_ADDR and WriteData==PASS_DATA SHALL move the FSM to PASS.
REQ-020 Otherwise, in RUN, a sampled MemWrite=1 with ALLOW_LO<=DataAdr<=ALLOW_HI SHALL keep the FSM in RUN and increment write_count.
REQ-021 Otherwise, in RUN, a sampled MemWrite=1 SHALL move the FSM to FAIL and load fail_addr/fail_data with DataAdr/WriteData on the same edge.
REQ-022 Consequence of REQ-020/021 precedence: a write to PASS_ADDR with wrong data SHALL be tolerated if PASS_ADDR lies inside the allow window, and SHALL cause FAIL if it lies outside.
REQ-023 cycle_count SHALL increment on every rising edge spent in RUN and freeze in any terminal state.
REQ-024 With TIMEOUT!=0, when cycle_count==TIMEOUT-1 in RUN and no terminating write is sampled, the FSM SHALL enter TIMEOUT on that edge.
REQ-025 If a terminating write (PASS or FAIL) and timeout expiry coincide on the same edge, the write outcome SHALL win.
REQ-026 write_count and cycle_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 All outputs SHALL be registered; the status for a write sampled at edge N SHALL be visible immediately after edge N (zero extra latency).
REQ-028 done SHALL equal pass|fail|timeout; at most one of pass, fail, timeout SHALL ever be high.
REQ-029 Inputs SHALL be ignored in terminal states; fail_addr and fail_data SHALL hold their captured values.
REQ-030 X or Z on DataAdr or WriteData while MemWrite=0 SHALL have no effect on state.

Reset
REQ-031 When reset=0 at a rising edge, the state SHALL become RUN and done, pass, fail, timeout, fail_addr, fail_data, write_count and cycle_count SHALL all become 0.
REQ-032 Reset SHALL take priority over every other event, including a write sampled on the same edge.
REQ-033 Asserting reset mid-run or in a terminal state SHALL fully restart the check, with no residual counts.

Verification
REQ-034 The bench SHALL cover: reset low 2 cycles, then writes (96,7),(96,9),(100,25) -> pass=1 after third write edge, write_count=2, fail=0.
REQ-035 The bench SHALL cover: after reset, write (104,5) -> fail=1, fail_addr=104, fail_data=5; a later (100,25) leaves pass=0.
REQ-036 The bench SHALL cover: TIMEOUT=10, no writes -> timeout=1 on the 10th RUN edge, cycle_count=9 frozen.
REQ-037 The bench SHALL cover: TIMEOUT=10, (100,25) on the 10th RUN edge -> pass=1, timeout=0.
REQ-038 The bench SHALL cover: ALLOW_LO=96, ALLOW_HI=100, write (100,4) -> stays RUN, write_count=1; then (100,25) -> pass=1.
REQ-039 The bench SHALL cover: reset=0 on the same edge as (100,25) -> pass=0 and all counters 0; CNT_W=4 with 20 scratch writes -> write_count=15.
